imm_decode_fifo: RTL and testbench

- Registered, parametrised immediate generator for the multi-cycle RISC-V core.
- Accepts instruction words over valid/ready and decodes every RV32I/RV64I immediate format (I, shift-I, S, B, U, J).
- Buffers results in a DEPTH-entry FIFO so fetch can run ahead of the execute sequencer.
- Flags illegal/unknown opcodes and supports a synchronous flush for redirects.

---
 rtl/imm_decode_fifo_if.sv | 25 ++
 rtl/imm_decode_fifo.sv | 129 ++++++++++++
 tb/tb_imm_decode_fifo.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_decode_fifo_if.sv
// Producer/consumer bundle for the immediate decoder: instruction push side and decoded-immediate pop side.
// Handshake: a beat transfers on a rising edge where valid && ready; valid never waits on ready.
interface imm_decode_fifo_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  // master drives instructions and consumes results; slave is the decoder FIFO
  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/imm_decode_fifo.sv
// RISC-V immediate decoder (I, shift-I, S, B, U, J) feeding a DEPTH-entry FIFO.
// Decode happens on push; the head entry is presented registered, zeroed when the FIFO is empty.
module imm_decode_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  imm_decode_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_SHAMT = 3'd2;
  localparam logic [2:0] FMT_S     = 3'd3;
  localparam logic [2:0] FMT_B     = 3'd4;
  localparam logic [2:0] FMT_U     = 3'd5;
  localparam logic [2:0] FMT_J     = 3'd6;

  typedef struct packed {
    logic            illegal;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  entry_t          dec;
  entry_t          head;
  logic [31:0]     instr;
  logic [5:0]      shamt;
  logic            push;
  logic            pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign instr = bus.in_instr;
  // RV64 shifts take a 6-bit shamt; RV32 ignores instr[25]
  assign shamt = {(XLEN == 64) & instr[25], instr[24:20]};

  always_comb begin
    dec.imm     = '0;
    dec.fmt     = FMT_NONE;
    dec.illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      dec.illegal = 1'b1;
    end else begin
      case (instr[6:0])
        7'b0000011, 7'b1100111, 7'b1110011: begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(instr[31:20]));
        end
        7'b0010011: begin
          if (instr[13:12] == 2'b01) begin
            dec.fmt = FMT_SHAMT;
            dec.imm = XLEN'(shamt);
          end else begin
            dec.fmt = FMT_I;
            dec.imm = XLEN'($signed(instr[31:20]));
          end
        end
        7'b0100011: begin
          dec.fmt = FMT_S;
          dec.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
        end
        7'b1100011: begin
          dec.fmt = FMT_B;
          dec.imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        end
        7'b0110111, 7'b0010111: begin
          dec.fmt = FMT_U;
          dec.imm = XLEN'($signed({instr[31:12], 12'b0}));
        end
        7'b1101111: begin
          dec.fmt = FMT_J;
          dec.imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        end
        7'b0110011: begin
          dec.fmt = FMT_NONE;
        end
        default: begin
          dec.illegal = 1'b1;
        end
      endcase
    end
  end

  // in_ready depends only on occupancy and reset, never on out_ready
  assign bus.in_ready  = (count < CW'(DEPTH)) && !rst;
  assign bus.out_valid = (count != '0);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  assign head            = bus.out_valid ? mem[rd_ptr] : '0;
  assign bus.out_imm     = head.imm;
  assign bus.out_fmt     = head.fmt;
  assign bus.out_illegal = head.illegal;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_decode_fifo.sv
// Bench for imm_decode_fifo: a 32-bit/DEPTH=2 and a 64-bit/DEPTH=4 instance, directed vectors plus
// randomized traffic compared against an arithmetic decode model and a queue.
module tb_imm_decode_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush32;
  logic       flush64;
  logic [1:0] count32;
  logic [2:0] count64;

  imm_decode_fifo_if #(.XLEN(32)) b32 ();
  imm_decode_fifo_if #(.XLEN(64)) b64 ();

  imm_decode_fifo #(.XLEN(32), .DEPTH(2)) u32 (
    .clk(clk), .rst(rst), .flush(flush32), .bus(b32), .count(count32)
  );
  imm_decode_fifo #(.XLEN(64), .DEPTH(4)) u64 (
    .clk(clk), .rst(rst), .flush(flush64), .bus(b64), .count(count64)
  );

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl32 [10];
  vec_t tbl64 [5];
  ent_t q32 [$];
  ent_t q64 [$];
  logic [6:0] ops [10] = '{7'h03, 7'h67, 7'h73, 7'h13, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] o_imm(input bit s);
    return s ? b64.out_imm : {32'b0, b32.out_imm};
  endfunction
  function automatic logic [63:0] o_fmt(input bit s);
    return s ? 64'(b64.out_fmt) : 64'(b32.out_fmt);
  endfunction
  function automatic logic [63:0] o_ill(input bit s);
    return s ? 64'(b64.out_illegal) : 64'(b32.out_illegal);
  endfunction
  function automatic logic [63:0] o_valid(input bit s);
    return s ? 64'(b64.out_valid) : 64'(b32.out_valid);
  endfunction
  function automatic logic [63:0] o_rdy(input bit s);
    return s ? 64'(b64.in_ready) : 64'(b32.in_ready);
  endfunction
  function automatic logic [63:0] o_cnt(input bit s);
    return s ? 64'(count64) : 64'(count32);
  endfunction

  task automatic drive(input bit s, input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    if (s) begin
      b64.in_valid = v; b64.in_instr = ins; b64.out_ready = rdy; flush64 = fl;
    end else begin
      b32.in_valid = v; b32.in_instr = ins; b32.out_ready = rdy; flush32 = fl;
    end
  endtask

  task automatic check_head(input bit s, input string nm, input logic vld, input logic [63:0] imm,
                            input logic [2:0] fmt, input logic ill);
    check({nm, "_valid"}, o_valid(s), 64'(vld));
    check({nm, "_imm"},   o_imm(s),   imm);
    check({nm, "_fmt"},   o_fmt(s),   64'(fmt));
    check({nm, "_ill"},   o_ill(s),   64'(ill));
  endtask

  // Reference decode: immediates assembled as signed integers from bit weights
  function automatic ent_t m_dec(input logic [31:0] ins, input bit is64);
    ent_t   e;
    longint v;
    v = 0; e.fmt = 3'd0; e.ill = 1'b0;
    if (ins[1:0] != 2'b11) begin
      e.ill = 1'b1;
    end else begin
      case (ins[6:0])
        7'h03, 7'h67, 7'h73: begin
          e.fmt = 3'd1; v = longint'(ins[31:20]); if (ins[31]) v -= 4096;
        end
        7'h13: begin
          if (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) begin
            e.fmt = 3'd2; v = is64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
          end else begin
            e.fmt = 3'd1; v = longint'(ins[31:20]); if (ins[31]) v -= 4096;
          end
        end
        7'h23: begin
          e.fmt = 3'd3; v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]); if (ins[31]) v -= 4096;
        end
        7'h63: begin
          e.fmt = 3'd4;
          v = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
            + longint'(ins[11:8]) * 2;
          if (ins[31]) v -= 8192;
        end
        7'h37, 7'h17: begin
          e.fmt = 3'd5; v = longint'(ins[31:12]) * 4096; if (ins[31]) v -= 64'sh1_0000_0000;
        end
        7'h6F: begin
          e.fmt = 3'd6;
          v = longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
            + longint'(ins[30:21]) * 2;
          if (ins[31]) v -= 2097152;
        end
        7'h33: e.fmt = 3'd0;
        default: e.ill = 1'b1;
      endcase
    end
    e.imm = is64 ? 64'(v) : {32'b0, v[31:0]};
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 9)];
    return w;
  endfunction

  initial begin
    tbl32[0] = '{32'hFFC12083, 64'hFFFFFFFC, 3'd1, 1'b0};
    tbl32[1] = '{32'h00512423, 64'h00000008, 3'd3, 1'b0};
    tbl32[2] = '{32'hFE000CE3, 64'hFFFFFFF8, 3'd4, 1'b0};
    tbl32[3] = '{32'h001000EF, 64'h00000800, 3'd6, 1'b0};
    tbl32[4] = '{32'h4051D093, 64'h00000005, 3'd2, 1'b0};
    tbl32[5] = '{32'h00000000, 64'h00000000, 3'd0, 1'b1};
    tbl32[6] = '{32'h0000007F, 64'h00000000, 3'd0, 1'b1};
    tbl32[7] = '{32'h002081B3, 64'h00000000, 3'd0, 1'b0};
    tbl32[8] = '{32'h02051093, 64'h00000000, 3'd2, 1'b0};
    tbl32[9] = '{32'h800000B7, 64'h80000000, 3'd5, 1'b0};
    tbl64[0] = '{32'h123450B7, 64'h0000000012345000, 3'd5, 1'b0};
    tbl64[1] = '{32'h800000B7, 64'hFFFFFFFF80000000, 3'd5, 1'b0};
    tbl64[2] = '{32'hFFC12083, 64'hFFFFFFFFFFFFFFFC, 3'd1, 1'b0};
    tbl64[3] = '{32'h02051093, 64'h0000000000000020, 3'd2, 1'b0};
    tbl64[4] = '{32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 3'd4, 1'b0};

    // reset state
    rst = 1'b1;
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_head(s[0], "reset", 1'b0, 64'h0, 3'd0, 1'b0);
      check("reset_count", o_cnt(s[0]), 64'h0);
      check("reset_in_ready", o_rdy(s[0]), 64'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready32", o_rdy(0), 64'h1);
    check("post_reset_in_ready64", o_rdy(1), 64'h1);

    // single-push decode vectors
    foreach (tbl32[i]) begin
      drive(0, 1'b1, tbl32[i].instr, 1'b1, 1'b0);
      @(negedge clk);
      check_head(0, $sformatf("tbl32_%0d", i), 1'b1, tbl32[i].imm, tbl32[i].fmt, tbl32[i].ill);
      drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      check_head(0, $sformatf("tbl32_drain_%0d", i), 1'b0, 64'h0, 3'd0, 1'b0);
    end
    foreach (tbl64[i]) begin
      drive(1, 1'b1, tbl64[i].instr, 1'b1, 1'b0);
      @(negedge clk);
      check_head(1, $sformatf("tbl64_%0d", i), 1'b1, tbl64[i].imm, tbl64[i].fmt, tbl64[i].ill);
      drive(1, 1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clk);
      check("tbl64_drain_valid", o_valid(1), 64'h0);
    end

    // back-to-back pushes with continuous pop: one result per cycle, in order
    for (int i = 1; i <= 4; i++) begin
      drive(0, 1'b1, tbl32[i].instr, 1'b1, 1'b0);
      @(negedge clk);
      check_head(0, $sformatf("b2b_%0d", i), 1'b1, tbl32[i].imm, tbl32[i].fmt, tbl32[i].ill);
      check("b2b_count", o_cnt(0), 64'h1);
    end
    drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("b2b_empty", o_valid(0), 64'h0);

    // fill to DEPTH with out_ready low, then drain while the third entry waits
    drive(0, 1'b1, tbl32[1].instr, 1'b0, 1'b0);
    @(negedge clk);
    check("fill_count1", o_cnt(0), 64'h1);
    check("fill_rdy1", o_rdy(0), 64'h1);
    drive(0, 1'b1, tbl32[2].instr, 1'b0, 1'b0);
    @(negedge clk);
    check("fill_count2", o_cnt(0), 64'h2);
    check("fill_rdy_full", o_rdy(0), 64'h0);
    check_head(0, "fill_head", 1'b1, tbl32[1].imm, tbl32[1].fmt, 1'b0);
    drive(0, 1'b1, tbl32[3].instr, 1'b0, 1'b0);
    @(negedge clk);
    check("hold_count", o_cnt(0), 64'h2);
    check_head(0, "hold_head", 1'b1, tbl32[1].imm, tbl32[1].fmt, 1'b0);
    drive(0, 1'b1, tbl32[3].instr, 1'b1, 1'b0);
    @(negedge clk);
    check("drain1_count", o_cnt(0), 64'h1);
    check_head(0, "drain1_head", 1'b1, tbl32[2].imm, tbl32[2].fmt, 1'b0);
    @(negedge clk);
    check("pushpop_count", o_cnt(0), 64'h1);
    check_head(0, "pushpop_head", 1'b1, tbl32[3].imm, tbl32[3].fmt, 1'b0);
    drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("drain_empty_count", o_cnt(0), 64'h0);
    check("drain_empty_valid", o_valid(0), 64'h0);

    // flush with simultaneous push and pop
    drive(0, 1'b1, tbl32[1].instr, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, tbl32[2].instr, 1'b0, 1'b0);
    @(negedge clk);
    check("preflush_count", o_cnt(0), 64'h2);
    drive(0, 1'b1, tbl32[3].instr, 1'b1, 1'b1);
    @(negedge clk);
    check("flush_count", o_cnt(0), 64'h0);
    check_head(0, "flush", 1'b0, 64'h0, 3'd0, 1'b0);
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("postflush_count", o_cnt(0), 64'h0);

    // same with reset
    drive(0, 1'b1, tbl32[1].instr, 1'b0, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, tbl32[2].instr, 1'b0, 1'b0);
    @(negedge clk);
    check("prerst_count", o_cnt(0), 64'h2);
    rst = 1'b1;
    drive(0, 1'b1, tbl32[3].instr, 1'b1, 1'b0);
    #1;
    check("rst_in_ready_now", o_rdy(0), 64'h0);
    @(negedge clk);
    check("rst_count", o_cnt(0), 64'h0);
    check_head(0, "rst", 1'b0, 64'h0, 3'd0, 1'b0);
    check("rst_in_ready", o_rdy(0), 64'h0);
    @(negedge clk);
    check("rst_hold_in_ready", o_rdy(0), 64'h0);
    check("rst_hold_count", o_cnt(0), 64'h0);
    rst = 1'b0;
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_release_in_ready", o_rdy(0), 64'h1);
    check("rst_release_count", o_cnt(0), 64'h0);

    // randomized traffic on both instances against the queue model
    for (int c = 0; c < 600; c++) begin
      int rp;
      rp = (c / 150) * 30 + 10;
      for (int s = 0; s < 2; s++) begin
        int   sz;
        int   dep;
        ent_t h;
        logic v, r, f;
        logic [31:0] ins;
        sz  = s ? q64.size() : q32.size();
        dep = s ? 4 : 2;
        h   = '{64'h0, 3'd0, 1'b0};
        if (sz > 0) h = s ? q64[0] : q32[0];
        check("rnd_valid", o_valid(s[0]), 64'(sz != 0));
        check("rnd_count", o_cnt(s[0]), 64'(sz));
        check("rnd_in_ready", o_rdy(s[0]), 64'(sz < dep));
        check("rnd_imm", o_imm(s[0]), h.imm);
        check("rnd_fmt", o_fmt(s[0]), 64'(h.fmt));
        check("rnd_ill", o_ill(s[0]), 64'(h.ill));
        v   = $urandom_range(0, 3) != 0;
        r   = $urandom_range(0, 99) < rp;
        f   = $urandom_range(0, 40) == 0;
        ins = rand_instr();
        drive(s[0], v, ins, r, f);
        if (f) begin
          if (s) q64.delete(); else q32.delete();
        end else begin
          if (r && sz > 0) begin
            if (s) void'(q64.pop_front()); else void'(q32.pop_front());
          end
          if (v && sz < dep) begin
            if (s) q64.push_back(m_dec(ins, 1'b1)); else q32.push_back(m_dec(ins, 1'b0));
          end
        end
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
